fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Consumer end of the program-counter interface. Captures (pc, instruction) pairs from the fetch path into a small FIFO and hands them to decode over a valid/ready handshake.
- Applies backpressure to the PC register via fetch_stall.
- Discards all queued work on a taken jump (flush), so the PC redirect and the queue stay coherent.
- Sits between the PC/instruction-memory stage and the decode stage of the pipeline.

Parameters:
- N, 32, width of pc and instruction words.
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- CW, 3, width of the count output; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset; sampled on rising clk edge only.
- in_valid  input  1  fetch path presents a valid pc/instruction pair.
- in_pc  input  N  pc value of the presented instruction.
- in_instr  input  N  instruction word.
- in_ready  output  1  queue can accept this cycle (not full).
- fetch_stall  output  1  equals ~in_ready; drives the PC hold.
- flush  input  1  taken jump; discard all entries.
- out_valid  output  1  head entry is valid.
- out_pc  output  N  pc of the head entry.
- out_instr  output  N  instruction of the head entry.
- out_ready  input  1  decode accepts the head entry.
- count  output  CW  number of valid entries, 0..DEPTH.
- seq_err  output  1  sticky sequence-error flag (see Optional Feature).

Behaviour:
- Storage is DEPTH-entry circular buffer: wr_ptr, rd_ptr (log2(DEPTH) bits, natural wrap), count register.
- Reset (rst=1 at posedge): wr_ptr=0, rd_ptr=0, count=0, seq_err=0.
  - Outputs after reset: out_valid=0, in_ready=1, fetch_stall=0.
  - Entry contents are don't-care.
  - Reset overrides flush, push and pop in the same cycle.
- Push: in_valid & in_ready at posedge. Entry written at wr_ptr; wr_ptr+1.
- Pop: out_valid & out_ready at posedge. rd_ptr+1.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- in_ready = (count != DEPTH), combinational from the count register only; it never depends on out_ready (no full-bypass).
- out_valid = (count != 0).
- out_pc and out_instr = entry at rd_ptr; they hold stable while out_valid & ~out_ready.
- Latency: an entry pushed at edge t is visible on out_* after edge t (the next cycle). No empty-queue bypass: when empty, out_valid stays 0 in the push cycle.
- Simultaneous push and pop at 0 < count < DEPTH: both happen; count unchanged.
- Full (count == DEPTH): in_valid is ignored; pop is still legal and in_ready rises the following cycle.
- Empty: out_ready is ignored.
- Flush at posedge:
  - wr_ptr=0, rd_ptr=0, count=0.
  - A push presented in the same cycle is dropped.
  - A pop presented in the same cycle has no additional effect.
  - out_valid=0 the cycle after.
  - Flush does not clear seq_err.
- Pointers wrap from DEPTH-1 to 0 with no gap; full and empty are distinguished by count alone.

Optional Feature:
- Macro: FETCH_QUEUE_SEQ_CHECK_EN.
- Enabled:
  - Add register last_pc (N bits) and flag have_last. Both are cleared by rst and by flush.
  - On each accepted push: if have_last and in_pc != last_pc+1 (mod 2^N), set seq_err=1.
  - On each accepted push, then load last_pc=in_pc and set have_last=1.
  - seq_err is sticky until rst.
  - The check catches a PC register that neither increments by 1 nor was redirected through flush.
- Disabled: no extra registers; seq_err tied to 0.

Test Plan:
- Reset then push pc=0x10..0x13 with out_ready=0 -> count=4, in_ready=0, fetch_stall=1. Then hold out_ready=1 -> out_pc=0x10,0x11,0x12,0x13 on consecutive cycles; count reaches 0; out_valid=0.
- Empty queue, push pc=0x20 at edge t -> out_valid=0 during cycle t; out_valid=1 with out_pc=0x20 after edge t.
- count=2, simultaneous push (pc=0x32) and pop every cycle for 10 cycles -> count stays 2; pointers wrap past 3; head order is strictly increasing.
- count=3, assert flush with in_valid=1, in_pc=0x40 -> next cycle count=0, out_valid=0, in_ready=1; 0x40 never appears at out_pc.
- Full queue, out_ready=1 and in_valid=1 same cycle -> pop only; count=3; in_ready=1 the next cycle; the in_valid entry is not stored.
- With FETCH_QUEUE_SEQ_CHECK_EN: push 0x50, 0x51, then 0x53 -> seq_err=1 after the third push. Then flush and push 0x80 -> seq_err stays 1; rst clears it to 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch queue: buffers (pc, instruction) pairs between the PC/imem stage and decode.
// Optional PC sequence checker enabled by defining FETCH_QUEUE_SEQ_CHECK_EN.
module fetch_queue #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [N-1:0]  in_pc,
  input  logic [N-1:0]  in_instr,
  output logic          in_ready,
  output logic          fetch_stall,
  input  logic          flush,
  output logic          out_valid,
  output logic [N-1:0]  out_pc,
  output logic [N-1:0]  out_instr,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          seq_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  pc_mem_q    [DEPTH];
  logic [N-1:0]  instr_mem_q [DEPTH];
  logic          push, pop;

  // in_ready depends on the count register only, so a full queue never accepts
  // in the same cycle it pops.
  assign in_ready    = (count_q != FULL);
  assign fetch_stall = ~in_ready;
  assign out_valid   = (count_q != '0);
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign out_pc      = pc_mem_q[rd_ptr_q];
  assign out_instr   = instr_mem_q[rd_ptr_q];
  assign count       = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A write under flush is harmless: the pointers reset, so the slot is dead.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= in_pc;
      instr_mem_q[wr_ptr_q] <= in_instr;
    end
  end

`ifdef FETCH_QUEUE_SEQ_CHECK_EN
  logic [N-1:0] last_pc_q, last_pc_d;
  logic         have_last_q, have_last_d;
  logic         seq_err_q, seq_err_d;

  always_comb begin
    last_pc_d   = last_pc_q;
    have_last_d = have_last_q;
    seq_err_d   = seq_err_q;
    if (flush) begin
      last_pc_d   = '0;
      have_last_d = 1'b0;
    end else if (push) begin
      if (have_last_q && (in_pc != last_pc_q + N'(1))) seq_err_d = 1'b1;
      last_pc_d   = in_pc;
      have_last_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc_q   <= '0;
      have_last_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      last_pc_q   <= last_pc_d;
      have_last_q <= have_last_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model plus directed vectors.
module tb_fetch_queue;
  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef FETCH_QUEUE_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, flush, out_ready;
  logic [N-1:0]  in_pc, in_instr;
  logic          in_ready, fetch_stall, out_valid, seq_err;
  logic [N-1:0]  out_pc, out_instr;
  logic [CW-1:0] count;

  fetch_queue #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(in_ready), .fetch_stall(fetch_stall), .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .count(count), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [N-1:0] instr_of(input logic [N-1:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Reference model: plain queue of pcs plus sequence-check state.
  logic [N-1:0] mq[$];
  logic         m_seq_err = 1'b0;
  logic         m_have    = 1'b0;
  logic [N-1:0] m_last    = '0;
  bit           cmp_en    = 1'b0;
  bit           bad_seen  = 1'b0;

  always @(posedge clk) begin
    bit p, q;
    if (rst) begin
      mq.delete();
      m_seq_err = 1'b0;
      m_have    = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_have = 1'b0;
    end else begin
      p = in_valid && (mq.size() < DEPTH);
      q = out_ready && (mq.size() > 0);
      if (q) void'(mq.pop_front());
      if (p) begin
        if (m_have && (in_pc != m_last + 1)) m_seq_err = 1'b1;
        m_last = in_pc;
        m_have = 1'b1;
        mq.push_back(in_pc);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("count", 64'(count), 64'(mq.size()));
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
      chk("fetch_stall", 64'(fetch_stall), 64'(mq.size() == DEPTH));
      chk("seq_err", 64'(seq_err), 64'(SEQ_EN ? m_seq_err : 1'b0));
      if (mq.size() != 0) begin
        chk("out_pc", 64'(out_pc), 64'(mq[0]));
        chk("out_instr", 64'(out_instr), 64'(instr_of(mq[0])));
      end
      if (out_valid && (out_pc == 32'h40 || out_pc == 32'h70)) bad_seen = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] pc, input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    step(); step();
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_fetch_stall", 64'(fetch_stall), 64'd0);
    chk("rst_seq_err", 64'(seq_err), 64'd0);

    // Fill to full with decode stalled, then drain.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10 + N'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_stall", 64'(fetch_stall), 64'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      chk("drain_pc", 64'(out_pc), 64'(32'h10 + i));
      step();
    end
    chk("drained_count", 64'(count), 64'd0);
    chk("drained_valid", 64'(out_valid), 64'd0);

    // No empty bypass.
    drive(1'b1, 32'h20, 1'b0, 1'b0);
    #1 chk("nobypass_valid", 64'(out_valid), 64'd0);
    step();
    chk("latency_valid", 64'(out_valid), 64'd1);
    chk("latency_pc", 64'(out_pc), 64'h20);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();

    // Steady state push+pop at count 2, pointers wrap.
    drive(1'b1, 32'h30, 1'b0, 1'b0); step();
    drive(1'b1, 32'h31, 1'b0, 1'b0); step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h32 + N'(i), 1'b1, 1'b0);
      chk("steady_head", 64'(out_pc), 64'(32'h30 + i));
      step();
      chk("steady_count", 64'(count), 64'd2);
    end
    drive(1'b1, 32'h3C, 1'b0, 1'b0); step();
    chk("pre_flush_count", 64'(count), 64'd3);

    // Flush drops the concurrent push.
    drive(1'b1, 32'h40, 1'b1, 1'b1); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    step(); step();

    // Full: pop only, in_valid ignored.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h60 + N'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h70, 1'b1, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("fullpop_count", 64'(count), 64'd3);
    chk("fullpop_in_ready", 64'(in_ready), 64'd1);
    chk("fullpop_head", 64'(out_pc), 64'h61);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      chk("fullpop_drain", 64'(out_pc), 64'(32'h61 + i));
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("fullpop_empty", 64'(count), 64'd0);
    chk("dropped_never_seen", 64'(bad_seen), 64'd0);

    // Sequence checker.
    rst = 1'b1; step(); rst = 1'b0;
    drive(1'b1, 32'h50, 1'b1, 1'b0); step();
    drive(1'b1, 32'h51, 1'b1, 1'b0); step();
    chk("seq_ok", 64'(seq_err), 64'd0);
    drive(1'b1, 32'h53, 1'b1, 1'b0); step();
    chk("seq_gap", 64'(seq_err), 64'(SEQ_EN));
    drive(1'b0, '0, 1'b1, 1'b1); step();
    drive(1'b1, 32'h80, 1'b1, 1'b0); step();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("seq_sticky", 64'(seq_err), 64'(SEQ_EN));
    step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("seq_rst", 64'(seq_err), 64'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
